forwarding_control: RTL and testbench

//  Producer side of the decode-stage operand bypass. Tracks destination registers of
//  in-flight instructions in EXE and the EW_LAYER+1 write layers. Compares them against
//  the sources of the instruction at the decode-queue head, and drives the one-hot

---
 rtl/forwarding_control.sv | 109 ++++++++++
 tb/tb_forwarding_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/forwarding_control.sv
// forwarding_control: decode-stage operand bypass producer.
// Tracks destinations of the instruction in EXE plus EW_LAYER+1 write layers,
// matches them against the decode-queue head sources and drives one-hot
// forward selects (youngest producer wins) and a load-use stall request.
module forwarding_control #(
  parameter int EW_LAYER   = 1,
  parameter int LOAD_LAYER = 0,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  deq_valid_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_d_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_s_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_t_head,
  input  logic                  deq_use_d_head,
  input  logic                  deq_use_s_head,
  input  logic                  deq_use_t_head,
  input  logic                  de_wr_en,
  input  logic                  de_is_load,
  input  logic [REG_ADDR_W-1:0] de_reg_addr_d,
  output logic                  forward_to_d_from_exe,
  output logic                  forward_to_s_from_exe,
  output logic                  forward_to_t_from_exe,
  output logic [EW_LAYER:0]     forward_to_d_from_wri,
  output logic [EW_LAYER:0]     forward_to_s_from_wri,
  output logic [EW_LAYER:0]     forward_to_t_from_wri,
  output logic                  hazard_stall
);

  localparam int NW = EW_LAYER + 1;

  // Write-layer slots; index 0 is the youngest.
  logic [NW-1:0]         r_valid;
  logic [NW-1:0]         r_load;
  logic [REG_ADDR_W-1:0] r_addr [NW];

  // flush needs no action here: older instructions still commit and the
  // decode phase zeroes de_* itself, so the EXE slot goes invalid on its own.
  logic w_flush_unused;
  assign w_flush_unused = flush;

  // Operand views indexed 0=d, 1=s, 2=t.
  logic [REG_ADDR_W-1:0] w_addr [3];
  logic [2:0]            w_use;
  assign w_addr[0] = deq_reg_addr_d_head;
  assign w_addr[1] = deq_reg_addr_s_head;
  assign w_addr[2] = deq_reg_addr_t_head;
  assign w_use     = {deq_use_t_head, deq_use_s_head, deq_use_d_head};

  // Slots always advance; stall only holds the decode head, not later stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_load  <= '0;
      for (int k = 0; k < NW; k++) r_addr[k] <= '0;
    end else begin
      r_valid[0] <= de_wr_en;
      r_load[0]  <= de_is_load;
      r_addr[0]  <= de_reg_addr_d;
      for (int k = 1; k < NW; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_load[k]  <= r_load[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
    end
  end

  logic [2:0]    w_sel_exe;
  logic [2:0]    w_stall_op;
  logic [NW-1:0] w_sel_wri [3];
  logic          w_blocked;

  // Per-operand priority match: exe, then wri[0] .. wri[EW_LAYER]; the first
  // hit blocks all older ones. A winning load whose data is not yet on a
  // bypass point marks that operand as stalled.
  always_comb begin
    w_sel_exe  = '0;
    w_stall_op = '0;
    w_blocked  = 1'b0;
    for (int op = 0; op < 3; op++) w_sel_wri[op] = '0;
    for (int op = 0; op < 3; op++) begin
      w_blocked = deq_valid_head & w_use[op] & de_wr_en &
                  (de_reg_addr_d == w_addr[op]);
      w_sel_exe[op]  = w_blocked;
      w_stall_op[op] = w_blocked & de_is_load;
      for (int k = 0; k < NW; k++) begin
        if (!w_blocked && deq_valid_head && w_use[op] && r_valid[k] &&
            (r_addr[k] == w_addr[op])) begin
          w_sel_wri[op][k] = 1'b1;
          w_blocked        = 1'b1;
          if (r_load[k] && (k < LOAD_LAYER)) w_stall_op[op] = 1'b1;
        end
      end
    end
  end

  // Selects of a stalled operand are suppressed; everything is held low
  // while reset is asserted, since the EXE slot is not reset-qualified.
  assign forward_to_d_from_exe = rstn & ~w_stall_op[0] & w_sel_exe[0];
  assign forward_to_s_from_exe = rstn & ~w_stall_op[1] & w_sel_exe[1];
  assign forward_to_t_from_exe = rstn & ~w_stall_op[2] & w_sel_exe[2];
  assign forward_to_d_from_wri = (rstn & ~w_stall_op[0]) ? w_sel_wri[0] : '0;
  assign forward_to_s_from_wri = (rstn & ~w_stall_op[1]) ? w_sel_wri[1] : '0;
  assign forward_to_t_from_wri = (rstn & ~w_stall_op[2]) ? w_sel_wri[2] : '0;
  assign hazard_stall          = rstn & (|w_stall_op);

endmodule

// File: tb/tb_forwarding_control.sv
// tb_forwarding_control: directed vectors with a scoreboard queue.
// The driver applies one cycle of inputs and pushes the expected output
// vector; the monitor pops and compares on the following falling edge.
module tb_forwarding_control;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       deq_valid_head;
  logic [4:0] deq_reg_addr_d_head, deq_reg_addr_s_head, deq_reg_addr_t_head;
  logic       deq_use_d_head, deq_use_s_head, deq_use_t_head;
  logic       de_wr_en, de_is_load;
  logic [4:0] de_reg_addr_d;
  logic       forward_to_d_from_exe, forward_to_s_from_exe, forward_to_t_from_exe;
  logic [1:0] forward_to_d_from_wri, forward_to_s_from_wri, forward_to_t_from_wri;
  logic       hazard_stall;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;
  exp_t sb_q[$];

  forwarding_control #(.EW_LAYER(1), .LOAD_LAYER(1), .REG_ADDR_W(5)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .flush                 (flush),
    .deq_valid_head        (deq_valid_head),
    .deq_reg_addr_d_head   (deq_reg_addr_d_head),
    .deq_reg_addr_s_head   (deq_reg_addr_s_head),
    .deq_reg_addr_t_head   (deq_reg_addr_t_head),
    .deq_use_d_head        (deq_use_d_head),
    .deq_use_s_head        (deq_use_s_head),
    .deq_use_t_head        (deq_use_t_head),
    .de_wr_en              (de_wr_en),
    .de_is_load            (de_is_load),
    .de_reg_addr_d         (de_reg_addr_d),
    .forward_to_d_from_exe (forward_to_d_from_exe),
    .forward_to_s_from_exe (forward_to_s_from_exe),
    .forward_to_t_from_exe (forward_to_t_from_exe),
    .forward_to_d_from_wri (forward_to_d_from_wri),
    .forward_to_s_from_wri (forward_to_s_from_wri),
    .forward_to_t_from_wri (forward_to_t_from_wri),
    .hazard_stall          (hazard_stall)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {exe d,s,t, wri_d[1:0], wri_s[1:0], wri_t[1:0], stall}
  function automatic logic [9:0] ev(input logic [2:0] exe, input logic [1:0] wd,
                                    input logic [1:0] ws, input logic [1:0] wt,
                                    input logic st);
    return {exe, wd, ws, wt, st};
  endfunction

  // One cycle of stimulus: applied 1 time unit after the rising edge.
  // use_dst = {use_d, use_s, use_t}.
  task automatic drive(input string nm, input logic rst_n_v, input logic fl,
                       input logic vh, input logic [4:0] ad, input logic [4:0] as_,
                       input logic [4:0] at, input logic [2:0] use_dst,
                       input logic wr, input logic ld, input logic [4:0] dst,
                       input logic [9:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rstn                = rst_n_v;
    flush               = fl;
    deq_valid_head      = vh;
    deq_reg_addr_d_head = ad;
    deq_reg_addr_s_head = as_;
    deq_reg_addr_t_head = at;
    deq_use_d_head      = use_dst[2];
    deq_use_s_head      = use_dst[1];
    deq_use_t_head      = use_dst[0];
    de_wr_en            = wr;
    de_is_load          = ld;
    de_reg_addr_d       = dst;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Monitor: the DUT response is combinational, so it is presented in the
  // same cycle the stimulus is applied; sample it on the falling edge.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {forward_to_d_from_exe, forward_to_s_from_exe, forward_to_t_from_exe,
               forward_to_d_from_wri, forward_to_s_from_wri, forward_to_t_from_wri,
               hazard_stall};
        tests_run++;
        if (act !== e.exp) begin
          tests_failed++;
          $display("[TB] FAIL %s: got %b, expected %b", e.name, act, e.exp);
        end else begin
          $display("[TB] ok   %s: %b", e.name, act);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    rstn = 1'b0; flush = 1'b0; deq_valid_head = 1'b0;
    deq_reg_addr_d_head = '0; deq_reg_addr_s_head = '0; deq_reg_addr_t_head = '0;
    deq_use_d_head = 1'b0; deq_use_s_head = 1'b0; deq_use_t_head = 1'b0;
    de_wr_en = 1'b0; de_is_load = 1'b0; de_reg_addr_d = '0;

    //     name          rstn fl vh  d   s   t  use   wr ld dst  expected
    // Reset gating and release
    drive("rst_hold0",   0, 0, 1, 0,  3,  0, 3'b010, 1, 0, 3,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("rst_hold1",   0, 0, 1, 0,  3,  0, 3'b010, 1, 0, 3,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("rst_release", 1, 0, 1, 0,  3,  0, 3'b010, 1, 0, 3,  ev(3'b010, 2'b00, 2'b00, 2'b00, 0));
    // EXE forward to d and s
    drive("exe_fwd_ds",  1, 0, 1, 5,  5,  0, 3'b110, 1, 0, 5,  ev(3'b110, 2'b00, 2'b00, 2'b00, 0));
    // Aging through the write layers
    drive("age_n",       1, 0, 1, 0,  2,  0, 3'b010, 1, 0, 2,  ev(3'b010, 2'b00, 2'b00, 2'b00, 0));
    drive("age_n1",      1, 0, 1, 0,  2,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b01, 2'b00, 0));
    drive("age_n2",      1, 0, 1, 0,  2,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b10, 2'b00, 0));
    drive("age_n3",      1, 0, 1, 0,  2,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    // Priority: youngest producer wins
    drive("head_invalid",1, 0, 0, 0,  0,  7, 3'b001, 1, 0, 7,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("exe_over_w0", 1, 0, 1, 0,  0,  7, 3'b001, 1, 0, 7,  ev(3'b001, 2'b00, 2'b00, 2'b00, 0));
    drive("w0_over_w1",  1, 0, 1, 0,  0,  7, 3'b001, 1, 0, 4,  ev(3'b000, 2'b00, 2'b00, 2'b01, 0));
    drive("t_exe_r4",    1, 0, 1, 0,  0,  4, 3'b001, 1, 0, 4,  ev(3'b001, 2'b00, 2'b00, 2'b00, 0));
    drive("addr0_fwd",   1, 0, 1, 0,  0,  0, 3'b100, 1, 0, 0,  ev(3'b100, 2'b00, 2'b00, 2'b00, 0));
    // Load-use with LOAD_LAYER=1
    drive("ld_exe",      1, 0, 1, 0,  6,  0, 3'b010, 1, 1, 6,  ev(3'b000, 2'b00, 2'b00, 2'b00, 1));
    drive("ld_w0",       1, 0, 1, 0,  6,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b00, 2'b00, 1));
    drive("ld_w1_fwd",   1, 0, 1, 0,  6,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b10, 2'b00, 0));
    drive("no_use",      1, 0, 1, 8,  0,  0, 3'b000, 1, 0, 8,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("stall_s_only",1, 0, 1, 8,  9,  0, 3'b110, 1, 1, 9,  ev(3'b000, 2'b01, 2'b00, 2'b00, 1));
    // Flush keeps slots
    drive("pre_flush",   1, 0, 0, 0,  1,  0, 3'b010, 1, 0, 1,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("flush_w0",    1, 1, 1, 0,  1,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b01, 2'b00, 0));
    drive("post_flush",  1, 0, 1, 0,  1,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b10, 2'b00, 0));
    drive("use_s_off",   1, 0, 1, 0, 12,  0, 3'b000, 1, 0, 12, ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("valid_off",   1, 0, 0, 0, 12,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("w1_r12",      1, 0, 1, 0, 12,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b10, 2'b00, 0));
    // Reset mid-operation drops tracking
    drive("pre_midrst",  1, 0, 1, 0, 13,  0, 3'b010, 1, 0, 13, ev(3'b010, 2'b00, 2'b00, 2'b00, 0));
    drive("midrst",      0, 0, 1, 0, 13,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));
    drive("post_midrst", 1, 0, 1, 0, 13,  0, 3'b010, 0, 0, 0,  ev(3'b000, 2'b00, 2'b00, 2'b00, 0));

    // Bounded drain of the scoreboard.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
